lcd_bus_responder: RTL
======================

Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-style responder for the 2x16 character-LCD bus driven by the menu/LCD controller.
- Decodes E/RS/RW/DATA writes into a 32-byte display mirror, display-control state and protocol-error flags.
- Used as a bench scoreboard for the LCD driver and as an on-chip mirror of the panel contents.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on all LCD bus inputs.
- MIN_E_HIGH, 12, minimum E-high width in clk cycles for a legal write strobe.
- CLR_BUSY, 82000, busy duration in clk cycles after Clear Display (1.64 ms at 50 MHz); must be >= 32.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- lcd_e  in  1  LCD enable strobe; data is latched on the falling edge.
- lcd_rs  in  1  0 = command, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read (reads are not supported).
- lcd_data  in  8  bus data.
- rd_addr  in  5  mirror read index: {line, column[3:0]}.
- rd_data  out  8  mirror byte, 1-cycle registered latency.
- disp_on / cursor_on / blink_on  out  1 each  Display On/Off control bits D, C, B.
- entry_inc  out  1  entry-mode I/D bit.
- func_2line  out  1  Function Set N bit.
- ac  out  7  address counter.
- busy  out  1  Clear Display in progress.
- cmd_strobe  out  1  one-cycle pulse per accepted command.
- data_strobe  out  1  one-cycle pulse per accepted data write.
- last_byte  out  8  byte of the last accepted access.
- err_busy / err_short / err_read  out  1 each  sticky protocol errors.

Behaviour:
- Reset values:
  - All outputs 0, except entry_inc = 1.
  - Mirror is not cleared by reset; it is cleared by Clear Display.
  - Reset mid-clear aborts the fill and deasserts busy on the next cycle.
- Input path:
  - All bus inputs pass through SYNC_STAGES flops.
  - An E-high counter saturates at MIN_E_HIGH.
- Strobe on synchronised E falling edge, in priority order:
  - Counter < MIN_E_HIGH: set err_short, access discarded.
  - rw = 1: set err_read, access discarded.
  - busy = 1: set err_busy, access discarded.
  - Otherwise the access is accepted.
- Latency: an accepted access updates state and pulses its strobe 1 cycle after the falling edge is detected.
- Command decode by highest set bit (lower bits ignored):
  - 0x01 Clear Display: ac = 0, entry_inc = 1, busy = 1 for CLR_BUSY cycles. The fill writes 0x20 to mirror entries 0..31, one per cycle, in the first 32 busy cycles.
  - 0x02 Return Home: ac = 0; no busy.
  - 0x04 Entry Mode Set: entry_inc = bit1; shift bit S ignored.
  - 0x08 Display On/Off: D = bit2, C = bit1, B = bit0.
  - 0x10 Cursor/Display Shift: ignored, but cmd_strobe still pulses.
  - 0x20 Function Set: func_2line = bit3.
  - 0x40 Set CGRAM Address: ignored, cmd_strobe pulses.
  - 0x80 Set DDRAM Address: ac = data[6:0].
  - 0x00: no-op, no strobe.
- Data write:
  - If ac is in 0x00-0x0F or 0x40-0x4F, write mirror[{ac[6], ac[3:0]}]; otherwise not stored, but data_strobe still pulses.
  - Then step ac per entry_inc.
- Address counter wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - Set DDRAM Address to a value in 0x28-0x3F or 0x68-0x7F is accepted as written; the next increment goes to the next legal address above it, wrapping to 0x40 or 0x00.
- Read port: rd_data is the mirror at rd_addr, registered. A read in the same cycle as a write to that entry returns the old value.
- Error flags: sticky; cleared only by rst.
- Display outputs: not gated by lcd_on; that port is absent.

Decomposition:
- Shared package lcd_pkg:
  - Command opcode constants: CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM.
  - DDRAM line bases 0x00 and 0x40; line length 16; blank char 0x20.
- One sub-module, lcd_strobe_detect:
  - Synchroniser, E-high width counter, falling-edge pulse with valid/short qualifier.
  - Captures rs, rw and data at the edge.

Test Plan:
- Reset, then commands 0x38, 0x0C, 0x06 with 20-cycle E pulses -> func_2line = 1, disp_on = 1, cursor_on = 0, entry_inc = 1, three cmd_strobe pulses.
- 0x80 then data 0x41 -> mirror[0] = 0x41, ac = 0x01. Then 0xC0 and data 0x42 -> rd_addr = 16 gives rd_data = 0x42 one cycle later, ac = 0x41.
- Clear 0x01 -> busy high for exactly CLR_BUSY cycles, all 32 entries = 0x20, ac = 0. A data write during busy -> err_busy = 1, mirror unchanged.
- Data write with E high for 5 cycles -> err_short = 1, no data_strobe, ac unchanged.
- 0xA7, then data 0x55 -> ac = 0x40, nothing stored.
- Entry 0x04, then 0x80, then data 0x58 -> ac wraps to 0x67.
- A write with rw = 1 -> err_read = 1.
- Assert rst during a clear fill -> busy = 0 and ac = 0 next cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, DDRAM geometry and address-counter stepping for the LCD responder
package lcd_pkg;
  typedef enum logic [7:0] {
    CMD_NONE  = 8'h00,
    CMD_CLEAR = 8'h01,
    CMD_HOME  = 8'h02,
    CMD_ENTRY = 8'h04,
    CMD_DISP  = 8'h08,
    CMD_SHIFT = 8'h10,
    CMD_FUNC  = 8'h20,
    CMD_CGRAM = 8'h40,
    CMD_DDRAM = 8'h80
  } cmd_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT} clr_state_e;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam int LINE_LEN = 16;
  localparam logic [5:0] LINE_LAST = 6'd39;
  localparam logic [7:0] BLANK = 8'h20;
  function automatic cmd_e cmd_decode(input logic [7:0] d);
    cmd_decode = CMD_NONE;
    for (int i = 0; i < 8; i++)
      if (d[i]) cmd_decode = cmd_e'(8'h01 << i);
  endfunction
  // Offsets past the last column of a line jump to the neighbouring line.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    ac_step = inc ? (a[5:0] >= LINE_LAST ? (a[6] ? LINE0_BASE : LINE1_BASE) : a + 7'd1)
                  : (a[5:0] == 6'd0 ? ((a[6] ? LINE0_BASE : LINE1_BASE) | {1'b0, LINE_LAST})
                                    : (a[5:0] > LINE_LAST ? {a[6], LINE_LAST} : a - 7'd1));
  endfunction
endpackage

// File: rtl/lcd_strobe_detect.sv
// lcd_strobe_detect: synchronises the LCD bus and flags each E falling edge with its width check
module lcd_strobe_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       stb,
  output logic       short_pulse,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);
  localparam int CW = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] E_MIN = CW'(MIN_E_HIGH);
  logic [10:0] sync_q [SYNC_STAGES];
  logic e_s, e_d, fall;
  logic [CW-1:0] hi_cnt;
  assign e_s = sync_q[SYNC_STAGES-1][10];
  assign fall = e_d & ~e_s;
  // Bus fields are held from the last E-high cycle so they are stable when stb fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_d <= 1'b0;
      hi_cnt <= '0;
      stb <= 1'b0;
      short_pulse <= 1'b0;
      {rs, rw, data} <= '0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_d <= e_s;
      hi_cnt <= !e_s ? '0 : (hi_cnt == E_MIN ? hi_cnt : hi_cnt + 1'b1);
      stb <= fall;
      if (fall) short_pulse <= hi_cnt < E_MIN;
      if (e_s) {rs, rw, data} <= sync_q[SYNC_STAGES-1][9:0];
    end
  end
endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style bus slave mirroring a 2x16 display and its control state
module lcd_bus_responder import lcd_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 12,
  parameter int CLR_BUSY    = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       func_2line,
  output logic [6:0] ac,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       data_strobe,
  output logic [7:0] last_byte,
  output logic       err_busy,
  output logic       err_short,
  output logic       err_read
);
  localparam int BW = $clog2(CLR_BUSY);
  localparam logic [BW-1:0] BUSY_LAST = BW'(CLR_BUSY - 1);
  localparam logic [BW-1:0] FILL_LAST = BW'(31);
  clr_state_e state_q, state_d;
  logic [BW-1:0] busy_cnt;
  logic stb, short_pulse, s_rs, s_rw;
  logic [7:0] s_data, wd;
  logic acc, cmd_acc, dat_acc, fill_we, mem_we;
  logic [4:0] wa;
  cmd_e op;
  logic [7:0] mem [32];
  lcd_strobe_detect #(.SYNC_STAGES(SYNC_STAGES), .MIN_E_HIGH(MIN_E_HIGH)) u_det (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
    .stb(stb), .short_pulse(short_pulse), .rs(s_rs), .rw(s_rw), .data(s_data)
  );
  assign op = cmd_decode(s_data);
  assign acc = stb & ~short_pulse & ~s_rw & ~busy;
  assign cmd_acc = acc & ~s_rs;
  assign dat_acc = acc & s_rs;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_cnt <= '0;
    end else begin
      state_q <= state_d;
      busy_cnt <= state_q == ST_IDLE ? '0 : busy_cnt + 1'b1;
    end
  end
  always_comb begin
    state_d = state_q == ST_IDLE ? (cmd_acc && op == CMD_CLEAR ? ST_FILL : ST_IDLE)
            : busy_cnt == BUSY_LAST ? ST_IDLE
            : (state_q == ST_FILL && busy_cnt == FILL_LAST) ? ST_WAIT : state_q;
  end
  always_comb begin
    busy = state_q != ST_IDLE;
    fill_we = state_q == ST_FILL;
  end
  // The fill owns the write port while busy; data writes are rejected then.
  assign mem_we = fill_we | (dat_acc & (ac[5:0] < 6'(LINE_LEN)));
  assign wa = fill_we ? busy_cnt[4:0] : {ac[6], ac[3:0]};
  assign wd = fill_we ? BLANK : s_data;
  always_ff @(posedge clk) begin
    if (mem_we) mem[wa] <= wd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {disp_on, cursor_on, blink_on, func_2line} <= '0;
      entry_inc <= 1'b1;
      ac <= LINE0_BASE;
      {cmd_strobe, data_strobe, err_busy, err_short, err_read} <= '0;
      last_byte <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      cmd_strobe <= cmd_acc & (op != CMD_NONE);
      data_strobe <= dat_acc;
      err_short <= err_short | (stb & short_pulse);
      err_read <= err_read | (stb & ~short_pulse & s_rw);
      err_busy <= err_busy | (stb & ~short_pulse & ~s_rw & busy);
      if (acc) last_byte <= s_data;
      if (cmd_acc)
        case (op)
          CMD_CLEAR: begin
            ac <= LINE0_BASE;
            entry_inc <= 1'b1;
          end
          CMD_HOME:  ac <= LINE0_BASE;
          CMD_ENTRY: entry_inc <= s_data[1];
          CMD_DISP:  {disp_on, cursor_on, blink_on} <= s_data[2:0];
          CMD_FUNC:  func_2line <= s_data[3];
          CMD_DDRAM: ac <= s_data[6:0];
          default: ;
        endcase
      if (dat_acc) ac <= ac_step(ac, entry_inc);
    end
  end
endmodule
